// File: rtl/cache_ctrl.sv
// cache_ctrl: sequences one CPU load/store at a time through the combinational
// cache and a handshaked main-memory port. Read misses refill the cache from
// memory, writes go through to memory, and a watchdog aborts stalled memory
// transactions. All control outputs are registered from the next state.
module cache_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpuRead,
    input  logic             cpuWrite,
    input  logic [31:0]      cpuAddr,
    input  logic [31:0]      cpuWData,
    output logic             ready,
    output logic             done,
    output logic             error,
    output logic [31:0]      cpuRData,
    output logic             cacheRead,
    output logic             cacheWrite,
    output logic [31:0]      cacheAddr,
    output logic [31:0]      cacheWData,
    input  logic [31:0]      cacheRData,
    input  logic             cacheHit,
    output logic             memReq,
    output logic             memWe,
    output logic [31:0]      memAddr,
    output logic [31:0]      memWData,
    input  logic [31:0]      memRData,
    input  logic             memAck,
    output logic [CNT_W-1:0] hitCount,
    output logic [CNT_W-1:0] missCount
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_WR_CACHE = 3'd2,
        ST_MEM_RD   = 3'd3,
        ST_FILL     = 3'd4,
        ST_MEM_WR   = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Watchdog value seen during the last permitted memory cycle.
    localparam logic [15:0]      WD_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             abort_s;
    logic             wd_limit_s;
    logic [15:0]      wd_cnt_r;
    logic [31:0]      addr_r;
    logic [31:0]      mem_wdata_r;
    logic [31:0]      cache_wdata_r;
    logic [31:0]      cpu_rdata_r;
    logic [CNT_W-1:0] hit_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;
    logic             ready_s, done_s, cache_read_s, cache_write_s, mem_req_s, mem_we_s;
    logic             ready_r, done_r, error_r, cache_read_r, cache_write_r, mem_req_r, mem_we_r;

    assign wd_limit_s = (wd_cnt_r == WD_LAST);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; an ack arriving in the limit cycle beats the watchdog.
    always_comb begin
        state_next_s = state_r;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpuRead) begin
                    state_next_s = ST_LOOKUP;
                end else if (cpuWrite) begin
                    state_next_s = ST_WR_CACHE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (cacheHit) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_WR_CACHE: state_next_s = ST_MEM_WR;
            ST_MEM_RD: begin
                if (memAck) begin
                    state_next_s = ST_FILL;
                end else if (wd_limit_s) begin
                    state_next_s = ST_DONE;
                    abort_s      = 1'b1;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_FILL: state_next_s = ST_DONE;
            ST_MEM_WR: begin
                if (memAck) begin
                    state_next_s = ST_DONE;
                end else if (wd_limit_s) begin
                    state_next_s = ST_DONE;
                    abort_s      = 1'b1;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the strobes can be registered
    // and still line up with the state they belong to.
    always_comb begin
        ready_s       = 1'b0;
        done_s        = 1'b0;
        cache_read_s  = 1'b0;
        cache_write_s = 1'b0;
        mem_req_s     = 1'b0;
        mem_we_s      = 1'b0;
        case (state_next_s)
            ST_IDLE:     ready_s       = 1'b1;
            ST_LOOKUP:   cache_read_s  = 1'b1;
            ST_WR_CACHE: cache_write_s = 1'b1;
            ST_FILL:     cache_write_s = 1'b1;
            ST_MEM_RD:   mem_req_s     = 1'b1;
            ST_MEM_WR: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
            end
            ST_DONE:     done_s        = 1'b1;
            default:     ready_s       = 1'b0;
        endcase
    end

    // Registered control outputs; error is only ever set together with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r       <= 1'b1;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            cache_read_r  <= 1'b0;
            cache_write_r <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
        end else begin
            ready_r       <= ready_s;
            done_r        <= done_s;
            error_r       <= abort_s;
            cache_read_r  <= cache_read_s;
            cache_write_r <= cache_write_s;
            mem_req_r     <= mem_req_s;
            mem_we_r      <= mem_we_s;
        end
    end

    // Watchdog: zero outside memory states, so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= 16'd0;
        end else if ((state_r != ST_MEM_RD) && (state_r != ST_MEM_WR)) begin
            wd_cnt_r <= 16'd0;
        end else if (!memAck) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Request capture and read-result / fill-data latching.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r        <= 32'h0;
            mem_wdata_r   <= 32'h0;
            cache_wdata_r <= 32'h0;
            cpu_rdata_r   <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpuRead) begin
                        addr_r <= cpuAddr;
                    end else if (cpuWrite) begin
                        addr_r        <= cpuAddr;
                        mem_wdata_r   <= cpuWData;
                        cache_wdata_r <= cpuWData;
                    end
                end
                ST_LOOKUP: begin
                    if (cacheHit) begin
                        cpu_rdata_r <= cacheRData;
                    end
                end
                ST_MEM_RD: begin
                    if (memAck) begin
                        cpu_rdata_r   <= memRData;
                        cache_wdata_r <= memRData;
                    end else if (wd_limit_s) begin
                        cpu_rdata_r <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating hit/miss statistics from the cache probe cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
        end else if ((state_r == ST_LOOKUP) || (state_r == ST_WR_CACHE)) begin
            if (cacheHit) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
            end else begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end
        end
    end

    assign ready      = ready_r;
    assign done       = done_r;
    assign error      = error_r;
    assign cpuRData   = cpu_rdata_r;
    assign cacheRead  = cache_read_r;
    assign cacheWrite = cache_write_r;
    assign cacheAddr  = addr_r;
    assign cacheWData = cache_wdata_r;
    assign memReq     = mem_req_r;
    assign memWe      = mem_we_r;
    assign memAddr    = {addr_r[31:2], 2'b00};
    assign memWData   = mem_wdata_r;
    assign hitCount   = hit_cnt_r;
    assign missCount  = miss_cnt_r;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl. A second instance with 4-bit counters
// shares the stimulus so counter saturation is reachable in a short run.
module tb_cache_ctrl;

    logic        clk;
    logic        reset;
    logic        cpuRead, cpuWrite;
    logic [31:0] cpuAddr, cpuWData;
    logic [31:0] cacheRData, memRData;
    logic        cacheHit, memAck;

    logic        ready, done, error, cacheRead, cacheWrite, memReq, memWe;
    logic [31:0] cpuRData, cacheAddr, cacheWData, memAddr, memWData;
    logic [15:0] hitCount, missCount;

    logic        s_ready, s_done, s_error, s_cacheRead, s_cacheWrite, s_memReq, s_memWe;
    logic [31:0] s_cpuRData, s_cacheAddr, s_cacheWData, s_memAddr, s_memWData;
    logic [3:0]  s_hitCount, s_missCount;

    int n_checks;
    int n_errors;

    cache_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
        .cpuAddr(cpuAddr), .cpuWData(cpuWData), .ready(ready), .done(done),
        .error(error), .cpuRData(cpuRData), .cacheRead(cacheRead),
        .cacheWrite(cacheWrite), .cacheAddr(cacheAddr), .cacheWData(cacheWData),
        .cacheRData(cacheRData), .cacheHit(cacheHit), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .memAck(memAck), .hitCount(hitCount),
        .missCount(missCount)
    );

    cache_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
        .cpuAddr(cpuAddr), .cpuWData(cpuWData), .ready(s_ready), .done(s_done),
        .error(s_error), .cpuRData(s_cpuRData), .cacheRead(s_cacheRead),
        .cacheWrite(s_cacheWrite), .cacheAddr(s_cacheAddr), .cacheWData(s_cacheWData),
        .cacheRData(cacheRData), .cacheHit(cacheHit), .memReq(s_memReq),
        .memWe(s_memWe), .memAddr(s_memAddr), .memWData(s_memWData),
        .memRData(memRData), .memAck(memAck), .hitCount(s_hitCount),
        .missCount(s_missCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain read hit: accept, LOOKUP, DONE, back to IDLE.
    task automatic read_hit(input logic [31:0] a, input logic [31:0] d);
        cpuRead    = 1'b1;
        cpuAddr    = a;
        cacheHit   = 1'b1;
        cacheRData = d;
        tick();
        cpuRead = 1'b0;
        tick();
        check_eq("loop_done", {31'd0, done}, 32'd1);
        check_eq("loop_rdata", cpuRData, d);
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        cpuRead    = 1'b0;
        cpuWrite   = 1'b0;
        cpuAddr    = 32'h0;
        cpuWData   = 32'h0;
        cacheRData = 32'h0;
        cacheHit   = 1'b0;
        memRData   = 32'h0;
        memAck     = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_error", {31'd0, error}, 32'd0);
        check_eq("rst_rdata", cpuRData, 32'h0);
        check_eq("rst_memreq", {31'd0, memReq}, 32'd0);
        check_eq("rst_hits", {16'd0, hitCount}, 32'd0);
        check_eq("rst_miss", {16'd0, missCount}, 32'd0);
        reset = 1'b0;
        tick();
        check_eq("idle_ready", {31'd0, ready}, 32'd1);

        // Read hit at 0x4, cache returns 5
        cpuRead    = 1'b1;
        cpuAddr    = 32'h0000_0004;
        cacheHit   = 1'b1;
        cacheRData = 32'd5;
        tick();
        cpuRead = 1'b0;
        check_eq("hit_c1_cread", {31'd0, cacheRead}, 32'd1);
        check_eq("hit_c1_caddr", cacheAddr, 32'h0000_0004);
        check_eq("hit_c1_ready", {31'd0, ready}, 32'd0);
        check_eq("hit_c1_memreq", {31'd0, memReq}, 32'd0);
        tick();
        check_eq("hit_c2_done", {31'd0, done}, 32'd1);
        check_eq("hit_c2_error", {31'd0, error}, 32'd0);
        check_eq("hit_c2_rdata", cpuRData, 32'd5);
        check_eq("hit_c2_hits", {16'd0, hitCount}, 32'd1);
        check_eq("hit_c2_memreq", {31'd0, memReq}, 32'd0);
        tick();
        check_eq("hit_c3_ready", {31'd0, ready}, 32'd1);
        check_eq("hit_c3_done", {31'd0, done}, 32'd0);

        // Read miss at 0x408, ack in third MEM_RD cycle with 0xCAFE0001
        cpuRead  = 1'b1;
        cpuAddr  = 32'h0000_0408;
        cacheHit = 1'b0;
        tick();
        cpuRead = 1'b0;
        cpuAddr = 32'hFFFF_FFFF;
        check_eq("miss_c1_cread", {31'd0, cacheRead}, 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            check_eq("miss_memreq", {31'd0, memReq}, 32'd1);
            check_eq("miss_memwe", {31'd0, memWe}, 32'd0);
            check_eq("miss_memaddr", memAddr, 32'h0000_0408);
            check_eq("miss_cwrite", {31'd0, cacheWrite}, 32'd0);
            if (k == 2) begin
                memAck   = 1'b1;
                memRData = 32'hCAFE_0001;
            end
            tick();
        end
        memAck   = 1'b0;
        memRData = 32'hDEAD_BEEF;
        check_eq("fill_cwrite", {31'd0, cacheWrite}, 32'd1);
        check_eq("fill_cwdata", cacheWData, 32'hCAFE_0001);
        check_eq("fill_caddr", cacheAddr, 32'h0000_0408);
        check_eq("fill_memreq", {31'd0, memReq}, 32'd0);
        tick();
        check_eq("miss_c6_done", {31'd0, done}, 32'd1);
        check_eq("miss_c6_error", {31'd0, error}, 32'd0);
        check_eq("miss_c6_rdata", cpuRData, 32'hCAFE_0001);
        check_eq("miss_c6_miss", {16'd0, missCount}, 32'd1);
        tick();

        // Write-through 0x12345678 to 0x10, ack in first MEM_WR cycle
        cpuWrite = 1'b1;
        cpuAddr  = 32'h0000_0010;
        cpuWData = 32'h1234_5678;
        cacheHit = 1'b1;
        tick();
        cpuWrite = 1'b0;
        cpuWData = 32'h0;
        check_eq("wr_c1_cwrite", {31'd0, cacheWrite}, 32'd1);
        check_eq("wr_c1_cwdata", cacheWData, 32'h1234_5678);
        check_eq("wr_c1_memreq", {31'd0, memReq}, 32'd0);
        tick();
        check_eq("wr_c2_memreq", {31'd0, memReq}, 32'd1);
        check_eq("wr_c2_memwe", {31'd0, memWe}, 32'd1);
        check_eq("wr_c2_mwdata", memWData, 32'h1234_5678);
        check_eq("wr_c2_maddr", memAddr, 32'h0000_0010);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        check_eq("wr_c3_done", {31'd0, done}, 32'd1);
        check_eq("wr_c3_error", {31'd0, error}, 32'd0);
        check_eq("wr_c3_rdata", cpuRData, 32'hCAFE_0001);
        check_eq("wr_c3_hits", {16'd0, hitCount}, 32'd2);
        tick();
        check_eq("wr_c4_ready", {31'd0, ready}, 32'd1);

        // Read miss at 0x23 that times out (TIMEOUT=4), then a late ack
        cpuRead  = 1'b1;
        cpuAddr  = 32'h0000_0023;
        cacheHit = 1'b0;
        tick();
        cpuRead = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("to_memreq", {31'd0, memReq}, 32'd1);
            check_eq("to_memaddr", memAddr, 32'h0000_0020);
            tick();
        end
        check_eq("to_done", {31'd0, done}, 32'd1);
        check_eq("to_error", {31'd0, error}, 32'd1);
        check_eq("to_rdata", cpuRData, 32'h0);
        check_eq("to_memreq_off", {31'd0, memReq}, 32'd0);
        check_eq("to_no_fill", {31'd0, cacheWrite}, 32'd0);
        check_eq("to_miss", {16'd0, missCount}, 32'd2);
        memAck   = 1'b1;
        memRData = 32'h5555_AAAA;
        tick();
        memAck = 1'b0;
        check_eq("late_ready", {31'd0, ready}, 32'd1);
        check_eq("late_done", {31'd0, done}, 32'd0);
        check_eq("late_error", {31'd0, error}, 32'd0);
        check_eq("late_memreq", {31'd0, memReq}, 32'd0);
        tick();
        check_eq("late_c8_cwrite", {31'd0, cacheWrite}, 32'd0);
        check_eq("late_c8_rdata", cpuRData, 32'h0);

        // Read and write requested together: read path wins
        cpuRead    = 1'b1;
        cpuWrite   = 1'b1;
        cpuAddr    = 32'h0000_0030;
        cpuWData   = 32'hAAAA_5555;
        cacheHit   = 1'b1;
        cacheRData = 32'h0000_0077;
        tick();
        cpuRead  = 1'b0;
        cpuWrite = 1'b0;
        check_eq("both_cread", {31'd0, cacheRead}, 32'd1);
        check_eq("both_cwrite", {31'd0, cacheWrite}, 32'd0);
        tick();
        check_eq("both_done", {31'd0, done}, 32'd1);
        check_eq("both_rdata", cpuRData, 32'h0000_0077);
        check_eq("both_hits", {16'd0, hitCount}, 32'd3);
        tick();

        // Reset asserted while in MEM_RD
        cpuRead  = 1'b1;
        cpuAddr  = 32'h0000_0040;
        cacheHit = 1'b0;
        tick();
        cpuRead = 1'b0;
        tick();
        check_eq("mrst_memreq_on", {31'd0, memReq}, 32'd1);
        reset = 1'b1;
        tick();
        check_eq("mrst_memreq", {31'd0, memReq}, 32'd0);
        check_eq("mrst_ready", {31'd0, ready}, 32'd1);
        check_eq("mrst_hits", {16'd0, hitCount}, 32'd0);
        check_eq("mrst_miss", {16'd0, missCount}, 32'd0);
        check_eq("mrst_rdata", cpuRData, 32'h0);
        check_eq("mrst_caddr", cacheAddr, 32'h0);
        reset = 1'b0;
        tick();

        // 20 hits: 16-bit counter reads 20, 4-bit counter sticks at 15
        for (int k = 0; k < 20; k++) begin
            read_hit(32'h0000_0100 + 32'(k * 4), 32'h0000_1000 + 32'(k));
        end
        check_eq("sat_hits_wide", {16'd0, hitCount}, 32'd20);
        check_eq("sat_hits_small", {28'd0, s_hitCount}, 32'd15);
        check_eq("sat_miss_small", {28'd0, s_missCount}, 32'd0);
        check_eq("sat_ready", {31'd0, ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
